// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Parametrised UART receive engine. Generates its own oversampling tick,
//   takes a 3-sample majority vote at mid-bit, checks parity and stop bits
//   and hands each word to the consumer through a one-entry valid/ready
//   holding register.
//
//   Optional feature macro: UART_RX_BREAK_DETECT_EN
//     defined   : all-zero frames are reported as a one-cycle rx_break pulse
//                 and are not delivered; FSM waits in BREAK for a 1 bit.
//     undefined : rx_break tied 0; all-zero frames deliver 0 with frame error.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rxd            serial line, asynchronous, idle high
//   rx_data        received word (DATA_BITS wide), stable while rx_valid
//   rx_valid       holding register full
//   rx_ready       consumer accepts; pop on rx_valid && rx_ready
//   rx_frame_err   stop-bit sample was 0 for the held word
//   rx_parity_err  parity mismatch for the held word
//   rx_overrun     held word overwrote an unpopped word
//   rx_break       one-cycle break pulse
//
// state  | meaning
// IDLE   | waiting for a low line on a tick
// START  | validating start bit (majority 0 keeps going)
// DATA   | shifting in DATA_BITS bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP   | sampling STOP_BITS stop bits
// BREAK  | all-zero frame seen, waiting for a majority-1 bit
module uart_rx_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(DIV + 1);
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = 4;

  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic [2:0] ST_BREAK  = 3'd5;
`endif

  logic                 sync1, sync2;
  logic [TW-1:0]        tcnt;
  logic                 tick;
  logic [2:0]           state;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 smp_a, smp_b;
  logic                 maj;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 par_calc;
  logic                 load_pend, pend_ferr, pend_perr;
  logic                 last_stop;

  // free-running down-counter, tick on terminal count
  assign tick = (tcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else        tcnt <= tick ? TW'(DIV - 1) : tcnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  // third sample is the live synchronised value at s = OVERSAMPLE/2+1
  assign maj       = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

  always_comb begin
    par_calc = 1'b0;
    if (PARITY == 1)      par_calc = ~(^shreg ^ maj);
    else if (PARITY == 2) par_calc = ^shreg ^ maj;
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_pulse, zero_acc, par_bit;
  assign rx_break = brk_pulse;
`else
  assign rx_break = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      shreg     <= '0;
      ferr_acc  <= 1'b0;
      load_pend <= 1'b0;
      pend_ferr <= 1'b0;
      pend_perr <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_pulse <= 1'b0;
      zero_acc  <= 1'b1;
      par_bit   <= 1'b0;
`endif
    end else begin
      load_pend <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_pulse <= 1'b0;
`endif
      if (tick && state == ST_IDLE) begin
        if (!sync2) begin
          state    <= ST_START;
          s_cnt    <= '0;
          bit_cnt  <= '0;
          ferr_acc <= 1'b0;
          pend_perr <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_acc <= 1'b1;
          par_bit  <= 1'b0;
`endif
        end
      end else if (tick) begin
        s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + 1'b1;
        if (s_cnt == S_LO)  smp_a <= sync2;
        if (s_cnt == S_MID) smp_b <= sync2;
        case (state)
          ST_START: begin
            if (s_cnt == S_HI && maj) state <= ST_IDLE;
            else if (s_cnt == S_END) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (s_cnt == S_HI) shreg <= {maj, shreg[DATA_BITS-1:1]};
            else if (s_cnt == S_END) begin
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (s_cnt == S_HI) begin
              pend_perr <= par_calc;
`ifdef UART_RX_BREAK_DETECT_EN
              par_bit   <= maj;
`endif
            end else if (s_cnt == S_END) begin
              state   <= ST_STOP;
              bit_cnt <= '0;
            end
          end
          ST_STOP: begin
            if (s_cnt == S_HI) begin
              if (last_stop) begin
                // leave immediately so a back-to-back start edge is not missed
`ifdef UART_RX_BREAK_DETECT_EN
                if (zero_acc && !maj && shreg == '0 && !par_bit) begin
                  state     <= ST_BREAK;
                  brk_pulse <= 1'b1;
                end else
`endif
                begin
                  state     <= ST_IDLE;
                  load_pend <= 1'b1;
                  pend_ferr <= ferr_acc | ~maj;
                end
              end else begin
                ferr_acc <= ferr_acc | ~maj;
`ifdef UART_RX_BREAK_DETECT_EN
                zero_acc <= zero_acc & ~maj;
`endif
              end
            end else if (s_cnt == S_END) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef UART_RX_BREAK_DETECT_EN
          ST_BREAK: begin
            if (s_cnt == S_HI && maj) state <= ST_IDLE;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (load_pend) begin
      rx_data       <= shreg;
      rx_valid      <= 1'b1;
      rx_frame_err  <= pend_ferr;
      rx_parity_err <= pend_perr;
      rx_overrun    <= rx_valid && !rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Directed bench: 8N1 instance (a) and 8E1 instance (b), DIV=1, 16 clk/bit.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b;
  logic       ovr_a, ovr_b, brk_a, brk_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_FREQ(16000), .BAUD(1000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a),
    .rx_overrun(ovr_a), .rx_break(brk_a));

  uart_rx_core #(.CLK_FREQ(16000), .BAUD(1000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b),
    .rx_overrun(ovr_b), .rx_break(brk_b));

  // monitor on instance a: captures each rx_valid rise and pulse width
  int         rises = 0;
  int         hi_len = 0;
  int         last_len = 0;
  int         brk_cnt = 0;
  logic       prev_v = 1'b0;
  logic [7:0] cap_data [16];
  logic       cap_ferr [16];

  always @(negedge clk) begin
    if (valid_a && !prev_v) begin
      cap_data[rises % 16] = data_a;
      cap_ferr[rises % 16] = ferr_a;
      rises  = rises + 1;
      hi_len = 1;
    end else if (valid_a) begin
      hi_len = hi_len + 1;
    end else if (prev_v) begin
      last_len = hi_len;
    end
    if (brk_a) brk_cnt = brk_cnt + 1;
    prev_v = valid_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    @(negedge clk);
    if (sel) rxd_b = v; else rxd_a = v;
    repeat (15) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stopv);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, pbit);
    drive_bit(sel, stopv);
  endtask

  task automatic pop_a(input string tag);
    @(negedge clk);
    ready_a = 1'b1;
    @(negedge clk);
    chk(tag, {31'd0, valid_a}, 32'd0);
    ready_a = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, brk0;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_data",  {24'd0, data_a}, 32'd0);
    chk("rst_flags", {28'd0, ferr_a, perr_a, ovr_a, brk_a}, 32'd0);
    chk("rst_valid_b", {31'd0, valid_b}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: 8N1 0xA5, ready=1 -> one-clock valid pulse
    ready_a = 1'b1;
    base = rises;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t1_rises", rises - base, 32'd1);
    chk("t1_len", last_len, 32'd1);
    chk("t1_data", {24'd0, cap_data[base % 16]}, 32'hA5);
    chk("t1_ferr", {31'd0, cap_ferr[base % 16]}, 32'd0);
    chk("t1_perr", {31'd0, perr_a}, 32'd0);
    ready_a = 1'b0;

    // 2: even parity on instance b
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    chk("t2a_valid", {31'd0, valid_b}, 32'd1);
    chk("t2a_data", {24'd0, data_b}, 32'h3C);
    chk("t2a_perr", {31'd0, perr_b}, 32'd1);
    chk("t2a_ferr", {31'd0, ferr_b}, 32'd0);
    @(negedge clk); ready_b = 1'b1;
    @(negedge clk); ready_b = 1'b0;
    chk("t2a_pop", {30'd0, valid_b, perr_b}, 32'd0);
    send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("t2b_data", {24'd0, data_b}, 32'h3C);
    chk("t2b_perr", {31'd0, perr_b}, 32'd0);
    chk("t2b_valid", {31'd0, valid_b}, 32'd1);

    // 3: stop bit 0 -> framing error, then a clean frame
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    rxd_a = 1'b1;
    chk("t3_data", {24'd0, data_a}, 32'h55);
    chk("t3_ferr", {31'd0, ferr_a}, 32'd1);
    repeat (30) @(negedge clk);
    pop_a("t3_pop");
    chk("t3_ferr_clr", {31'd0, ferr_a}, 32'd0);
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    chk("t3_data2", {24'd0, data_a}, 32'h12);
    chk("t3_ferr2", {31'd0, ferr_a}, 32'd0);
    pop_a("t3_pop2");

    // 4: overrun with ready=0
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    chk("t4_data1", {24'd0, data_a}, 32'h11);
    chk("t4_ovr1", {31'd0, ovr_a}, 32'd0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("t4_data2", {24'd0, data_a}, 32'h22);
    chk("t4_ovr2", {31'd0, ovr_a}, 32'd1);
    chk("t4_valid", {31'd0, valid_a}, 32'd1);
    pop_a("t4_pop");
    chk("t4_ovr_clr", {31'd0, ovr_a}, 32'd0);

    // 5: 6-clock glitch rejected, then 0x81
    base = rises;
    @(negedge clk); rxd_a = 1'b0;
    repeat (6) @(negedge clk);
    rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_no_rise", rises - base, 32'd0);
    chk("t5_valid", {31'd0, valid_a}, 32'd0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    chk("t5_data", {24'd0, data_a}, 32'h81);
    chk("t5_flags", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
    pop_a("t5_pop");

    // 6: 20-bit break
    ready_a = 1'b1;
    base = rises;
    brk0 = brk_cnt;
    @(negedge clk); rxd_a = 1'b0;
    repeat (320) @(negedge clk);
    rxd_a = 1'b1;
    repeat (400) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("t6_no_rise", rises - base, 32'd0);
    chk("t6_brk", brk_cnt - brk0, 32'd1);
`else
    chk("t6_rise", {31'd0, (rises - base) >= 1}, 32'd1);
    chk("t6_data", {24'd0, cap_data[base % 16]}, 32'h00);
    chk("t6_ferr", {31'd0, cap_ferr[base % 16]}, 32'd1);
    chk("t6_brk", brk_cnt - brk0, 32'd0);
`endif
    ready_a = 1'b0;

    // 6b: reset mid-frame with a word held
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("t6r_held", {31'd0, valid_a}, 32'd1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rxd_a = 1'b1;
    @(negedge clk);
    chk("t6r_valid", {31'd0, valid_a}, 32'd0);
    chk("t6r_data", {24'd0, data_a}, 32'd0);
    chk("t6r_flags", {28'd0, ferr_a, perr_a, ovr_a, brk_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6r_idle", {31'd0, valid_a}, 32'd0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    chk("t6r_data2", {24'd0, data_a}, 32'hC3);
    chk("t6r_flags2", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
    pop_a("t6r_pop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
